// File: rtl/boilerplate_core.sv
// Saturating accumulator for an unsigned sample stream: an input register feeds a
// PARAM2-bit accumulator that sticks at all-ones once the range is exhausted.
module boilerplate_core #(
  parameter int PARAM1 = 10,
  parameter int PARAM2 = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PARAM1-1:0] in,
  output logic [PARAM2-1:0] out
);

  generate
    if (PARAM1 < 1) begin : g_bad_param1
      $error("boilerplate_core: PARAM1 must be >= 1");
    end
    if (PARAM2 < PARAM1) begin : g_bad_param2
      $error("boilerplate_core: PARAM2 must be >= PARAM1");
    end
  endgenerate

  logic [PARAM1-1:0] in_q;
  logic [PARAM2-1:0] acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [PARAM2:0]   sum;

  // One extra bit of headroom exposes overflow as sum[PARAM2].
  assign sum = {1'b0, acc_q} + {{(PARAM2 + 1 - PARAM1){1'b0}}, in_q};

  always_comb begin
    acc_d = sum[PARAM2-1:0];
    sat_d = sat_q;
    // Landing exactly on all-ones is not an overflow but still pins the flag.
    if (sat_q || sum[PARAM2] || (&sum[PARAM2-1:0])) begin
      acc_d = '1;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q  <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      in_q  <= in;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign out = acc_q;

endmodule

// File: tb/tb_boilerplate_core.sv
// Bench for boilerplate_core: a reference model pushes the expected out value for
// each edge into a queue, which is popped and compared just after that edge.
module tb_boilerplate_core;

  localparam int W_IN  = 10;
  localparam int W_OUT = 20;
  localparam logic [W_OUT-1:0] ONES = {W_OUT{1'b1}};

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic [W_IN-1:0]  in    = '0;
  logic [W_OUT-1:0] out;

  always #5 clk = ~clk;

  boilerplate_core #(.PARAM1(W_IN), .PARAM2(W_OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  int checks   = 0;
  int failures = 0;
  logic [W_OUT-1:0] exp_q[$];

  // Reference model state
  logic [W_IN-1:0]  m_in  = '0;
  logic [W_OUT-1:0] m_acc = '0;
  logic             m_sat = 1'b0;

  task automatic check(input string tag, input logic [W_OUT-1:0] got,
                       input logic [W_OUT-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_in  = '0;
    m_acc = '0;
    m_sat = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one rising edge using the currently driven input.
  task automatic model_edge();
    longint unsigned total;
    total = longint'(m_acc) + longint'(m_in);
    if (m_sat || total >= longint'(ONES)) begin
      m_acc = ONES;
      m_sat = 1'b1;
    end else begin
      m_acc = total[W_OUT-1:0];
    end
    m_in = in;
  endtask

  // Called at a falling edge with reset high: drive, predict, clock, compare.
  task automatic step(input logic [W_IN-1:0] v, input string tag);
    logic [W_OUT-1:0] exp;
    in = v;
    model_edge();
    exp_q.push_back(m_acc);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got %0d expected 1 entry", tag, out);
    end else begin
      exp = exp_q.pop_front();
      check(tag, out, exp);
    end
    @(negedge clk);
  endtask

  // Called at a falling edge: one full cycle in reset, then release at a falling edge.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    model_clear();
    #1;
    check({tag, "_async"}, out, '0);
    in = W_IN'($urandom_range(0, 1023));
    @(posedge clk);
    #1;
    check({tag, "_held"}, out, '0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // 1. Reset held from power-up while in toggles.
    for (int i = 0; i < 4; i++) begin
      in = W_IN'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      check("por_hold", out, '0);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    step(10'd300, "pre_mid");
    step(10'd200, "pre_mid");
    step(10'd0,   "pre_mid");
    check("acc_nonzero", out, 20'd500);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("mid_async_clear", out, '0);
    @(negedge clk);

    // 2. Single sample then zero.
    reset = 1'b1;
    step(10'd123, "t2");
    step(10'd0,   "t2");
    for (int i = 0; i < 3; i++) step(10'd0, "t2_hold");

    // 3. Two samples then zero.
    reset_pulse("t3_rst");
    step(10'd123, "t3");
    step(10'd456, "t3");
    for (int i = 0; i < 3; i++) step(10'd0, "t3");
    check("t3_sum", out, 20'd579);

    // 4. Full-scale input until saturation.
    reset_pulse("t4_rst");
    for (int i = 0; i < 1026; i++) step(10'd1023, "t4_ramp");
    check("t4_sat_value", out, ONES);
    for (int i = 0; i < 3; i++) step(10'd1023, "t4_sat_hold");
    for (int i = 0; i < 3; i++) step(10'd0, "t4_zero_hold");

    // 5. Reset from saturation clears the sticky flag.
    reset_pulse("t5_rst");
    for (int i = 0; i < 6; i++) step(10'd5, "t5");
    check("t5_sum", out, 20'd25);

    // Random stream against the model.
    reset_pulse("rnd_rst");
    for (int i = 0; i < 200; i++) step(W_IN'($urandom_range(0, 1023)), "rnd");

    // 6. Sample driven in the same cycle reset deasserts.
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    step(10'd1000, "t6_cap");
    step(10'd0,    "t6_out");
    check("t6_value", out, 20'd1000);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
